// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the configurable serial pattern detector.
package seq_det_pkg;

  // Widest pattern the helpers support; MAX_LEN must not exceed it.
  localparam int unsigned MASK_W = 32;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Requested length limited to what the history register can hold.
  function automatic int unsigned len_clamp(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

  // Mask with the low `len` bits set; callers truncate to their own width.
  function automatic logic [MASK_W-1:0] window_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++)
      if (i < len) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/seq_out_reg.sv
// One-entry valid/ready output register. Reloads in the same cycle the sink
// drains it, so a producer gated by can_load sustains one item per cycle.
module seq_out_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic load,
  input  logic load_data,
  input  logic sink_ready,
  output logic valid,
  output logic data,
  output logic can_load
);

  assign can_load = !valid || sink_ready;

  // Flush wins, then a new item, then drain; data holds once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (sink_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-configurable serial pattern detector: one match flag per consumed
// bit, overlapping or non-overlapping matches, saturating match counter.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_match,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W:0]   FILL_LIM = (LEN_W + 1)'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] pattern_q;
  logic [MAX_LEN-1:0] history;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill;
  logic               overlap_q;

  logic               can_load;
  logic               accept;
  logic [MAX_LEN-1:0] new_hist;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_nxt;
  logic               hit;

  // No bit is taken in a cfg_load cycle so the new pattern never sees stale data.
  assign in_ready = (state == RUN) && !cfg_load && can_load;
  assign accept   = in_valid && in_ready;

  // Window compare on the history as it will look after this bit shifts in.
  assign new_hist = MAX_LEN'({history, in_bit});
  assign mask     = MAX_LEN'(window_mask(32'(len_q)));
  assign fill_nxt = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
  assign hit      = (len_q != '0) && (fill_nxt >= {1'b0, len_q}) &&
                    ((new_hist & mask) == (pattern_q & mask));

  // FSM and configuration capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNCFG;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
    end else if (cfg_load) begin
      state     <= RUN;
      pattern_q <= cfg_pattern;
      len_q     <= LEN_W'(len_clamp(32'(cfg_len), MAX_LEN));
      overlap_q <= cfg_overlap;
    end
  end

  // History and fill; a non-overlapping match restarts the fill so the next
  // match needs a full window of fresh bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history <= '0;
      fill    <= '0;
    end else if (cfg_load) begin
      history <= '0;
      fill    <= '0;
    end else if (accept) begin
      history <= new_hist;
      if (hit && !overlap_q)
        fill <= '0;
      else
        fill <= (fill_nxt > FILL_LIM) ? FILL_MAX : fill_nxt[LEN_W-1:0];
    end
  end

  // Saturating match counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      match_count <= '0;
    else if (cfg_load)
      match_count <= '0;
    else if (accept && hit && (match_count != '1))
      match_count <= match_count + CNT_W'(1);
  end

  seq_out_reg u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (cfg_load),
    .load       (accept),
    .load_data  (hit),
    .sink_ready (out_ready),
    .valid      (out_valid),
    .data       (out_match),
    .can_load   (can_load)
  );

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed bench for param_seq_detector: vector table for the main streams,
// hand sequences for stall, reconfigure, length boundaries and saturation.
module tb_param_seq_detector;

  logic       clk;
  logic       rst_n;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic       out_match;
  logic [15:0] match_count;

  // Second instance with a narrow counter for saturation.
  logic       s_cfg_load;
  logic [7:0] s_cfg_pattern;
  logic [3:0] s_cfg_len;
  logic       s_cfg_overlap;
  logic       s_in_valid;
  logic       s_in_ready;
  logic       s_in_bit;
  logic       s_out_valid;
  logic       s_out_ready;
  logic       s_out_match;
  logic [3:0] s_match_count;

  int n_checks = 0;
  int n_fail   = 0;

  param_seq_detector #(.MAX_LEN(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_ready(in_ready), .in_bit(in_bit), .out_valid(out_valid),
    .out_ready(out_ready), .out_match(out_match), .match_count(match_count)
  );

  param_seq_detector #(.MAX_LEN(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cfg_load(s_cfg_load), .cfg_pattern(s_cfg_pattern),
    .cfg_len(s_cfg_len), .cfg_overlap(s_cfg_overlap), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .in_bit(s_in_bit), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_match(s_out_match), .match_count(s_match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cl;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       iv;
    logic       ib;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic       chk_om;
    logic       e_om;
    int         e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic cl, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, input logic iv, input logic ib, input logic ordy);
    cfg_load = cl; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    in_valid = iv; in_bit = ib; out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    vec_t v;
    v = '{cl:1'b1, pat:pat, len:len, ovl:ovl, iv:1'b0, ib:1'b0, ordy:1'b1,
          e_ir:1'b0, e_ov:1'b0, chk_om:1'b0, e_om:1'b0, e_cnt:0};
    vq.push_back(v);
  endtask

  task automatic add_bit(input logic ib, input logic e_om, input int e_cnt);
    vec_t v;
    v = '{cl:1'b0, pat:8'h00, len:4'd0, ovl:1'b0, iv:1'b1, ib:ib, ordy:1'b1,
          e_ir:1'b1, e_ov:1'b1, chk_om:1'b1, e_om:e_om, e_cnt:e_cnt};
    vq.push_back(v);
  endtask

  logic [12:0] sa_bits;
  logic [12:0] sa_m;
  logic [4:0]  sb_bits;
  logic [4:0]  sb_ov_m;
  logic [4:0]  sb_no_m;
  logic [7:0]  pat8;
  int          cnt;

  initial begin
    sa_bits = 13'b1101001101101;   // streamed LSB first
    sa_m    = 13'b1000001001000;   // matches on bits 3, 6, 12
    sb_bits = 5'b10101;
    sb_ov_m = 5'b10100;
    sb_no_m = 5'b00100;

    s_cfg_load = 1'b0; s_cfg_pattern = 8'h00; s_cfg_len = 4'd0; s_cfg_overlap = 1'b0;
    s_in_valid = 1'b0; s_in_bit = 1'b0; s_out_ready = 1'b1;

    // Reset and unconfigured: offered bits must be ignored.
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_match", 32'(out_match), 0);
    chk("rst_count", 32'(match_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("uncfg_in_ready", 32'(in_ready), 0);
      tick();
      chk("uncfg_out_valid", 32'(out_valid), 0);
      chk("uncfg_count", 32'(match_count), 0);
    end

    // Table: len=2 overlap stream, then 101 overlap vs non-overlap.
    add_cfg(8'b11, 4'd2, 1'b1);
    cnt = 0;
    for (int k = 0; k < 13; k++) begin
      cnt += int'(sa_m[k]);
      add_bit(sa_bits[k], sa_m[k], cnt);
    end
    vq.push_back('{cl:1'b0, pat:8'h00, len:4'd0, ovl:1'b0, iv:1'b0, ib:1'b0, ordy:1'b1,
                   e_ir:1'b1, e_ov:1'b0, chk_om:1'b1, e_om:1'b1, e_cnt:3});
    add_cfg(8'b101, 4'd3, 1'b1);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cnt += int'(sb_ov_m[k]);
      add_bit(sb_bits[k], sb_ov_m[k], cnt);
    end
    add_cfg(8'b101, 4'd3, 1'b0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      cnt += int'(sb_no_m[k]);
      add_bit(sb_bits[k], sb_no_m[k], cnt);
    end

    foreach (vq[i]) begin
      drive(vq[i].cl, vq[i].pat, vq[i].len, vq[i].ovl, vq[i].iv, vq[i].ib, vq[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vq[i].e_ir));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
      if (vq[i].chk_om)
        chk($sformatf("vec%0d_out_match", i), 32'(out_match), 32'(vq[i].e_om));
      chk($sformatf("vec%0d_count", i), 32'(match_count), 32'(vq[i].e_cnt));
    end

    // Backpressure: stall 3 cycles after result 0 and after result 3 (a match).
    drive(1'b1, 8'b11, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 13; k++) begin
      drive(1'b0, 8'b11, 4'd2, 1'b1, 1'b1, sa_bits[k], 1'b1);
      chk("bp_in_ready", 32'(in_ready), 1);
      tick();
      chk($sformatf("bp_match%0d", k), 32'(out_match), 32'(sa_m[k]));
      if (k == 0 || k == 3) begin
        for (int s = 0; s < 3; s++) begin
          drive(1'b0, 8'b11, 4'd2, 1'b1, 1'b1, sa_bits[k+1], 1'b0);
          chk("bp_stall_in_ready", 32'(in_ready), 0);
          tick();
          chk("bp_stall_valid", 32'(out_valid), 1);
          chk("bp_stall_match", 32'(out_match), 32'(sa_m[k]));
        end
      end
    end
    chk("bp_count", 32'(match_count), 3);

    // Reconfigure with a result pending.
    drive(1'b1, 8'b11, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'b11, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'b11, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rc_pre_match", 32'(out_match), 1);
    chk("rc_pre_count", 32'(match_count), 1);
    drive(1'b1, 8'b11, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rc_load_in_ready", 32'(in_ready), 0);
    tick();
    chk("rc_valid_dropped", 32'(out_valid), 0);
    chk("rc_count_cleared", 32'(match_count), 0);
    drive(1'b0, 8'b11, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rc_first_valid", 32'(out_valid), 1);
    chk("rc_first_match", 32'(out_match), 0);
    tick();
    chk("rc_second_match", 32'(out_match), 1);
    chk("rc_second_count", 32'(match_count), 1);

    // len = 0 never matches, even against an all-zero pattern.
    drive(1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      chk("len0_valid", 32'(out_valid), 1);
      chk("len0_match", 32'(out_match), 0);
    end
    chk("len0_count", 32'(match_count), 0);

    // len = 15 clamps to 8: only the full 8-bit window matches.
    pat8 = 8'hB3;
    drive(1'b1, pat8, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    for (int k = 7; k >= 0; k--) begin
      drive(1'b0, pat8, 4'd15, 1'b1, 1'b1, pat8[k], 1'b1);
      tick();
      chk($sformatf("len15_match_b%0d", k), 32'(out_match), (k == 0) ? 1 : 0);
    end
    drive(1'b0, pat8, 4'd15, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("len15_after_match", 32'(out_match), 0);
    chk("len15_count", 32'(match_count), 1);

    // len = 1 on the 4-bit-counter instance: first bit matches, count saturates.
    s_cfg_load = 1'b1; s_cfg_pattern = 8'h01; s_cfg_len = 4'd1; s_cfg_overlap = 1'b1;
    tick();
    s_cfg_load = 1'b0; s_in_valid = 1'b1; s_in_bit = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      chk("sat_match", 32'(s_out_match), 1);
      chk($sformatf("sat_count%0d", k), 32'(s_match_count), (k + 1 > 15) ? 15 : k + 1);
    end
    s_in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
